// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID stage and the hazard unit: pipeline
// control state encoding, reset/bubble defaults and jump-decode opcodes.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2
    } pipe_state_e;

    // sll $0,$0,0 is the canonical MIPS no-op.
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    // Opcodes the hazard unit decodes to raise IF_ID_Flush for jumps.
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset. Sticks at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    // Count up on each enabled edge until the all-ones ceiling.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage: owns the PC and IF/ID registers and applies the
// hazard unit's PCWrite / IF_ID_Write / IF_ID_Flush commands each cycle.
// Optional stall watchdog enabled by defining IF_ID_STALL_WATCHDOG_EN.
module if_id_pipe_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT,
    parameter int          CNT_W      = 16,
    parameter int          WDOG_LIMIT = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             IF_ID_Flush,
    input  logic [31:0]      NextPC,
    input  logic [31:0]      Instruction_in,
    input  logic [31:0]      PCPlus4_in,
    output logic [31:0]      PC,
    output logic [31:0]      IF_ID_Instruction,
    output logic [31:0]      IF_ID_PCPlus4,
    output logic             IF_ID_Valid,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             HangDetect
);

    pipe_state_e state;
    pipe_state_e state_next;

    // A stall is a frozen IF/ID with no flush; a flush during a stall
    // counts only as a flush.
    logic stall_evt;
    logic flush_evt;
    assign stall_evt = !IF_ID_Write && !IF_ID_Flush;
    assign flush_evt = IF_ID_Flush;

    // PC register: loads only when the hazard unit allows it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            PC <= RESET_PC;
        end else if (PCWrite) begin
            PC <= NextPC;
        end
    end

    // IF/ID register: flush beats write, write beats hold. Instruction_in
    // is only sampled on the write path, so X on a stalled/flushed cycle
    // never reaches ID.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            IF_ID_Instruction <= NOP_INSTR;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
        end else if (IF_ID_Flush) begin
            IF_ID_Instruction <= NOP_INSTR;
            IF_ID_PCPlus4     <= '0;
            IF_ID_Valid       <= 1'b0;
        end else if (IF_ID_Write) begin
            IF_ID_Instruction <= Instruction_in;
            IF_ID_PCPlus4     <= PCPlus4_in;
            IF_ID_Valid       <= 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode from the current state and this cycle's commands.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next
        // unassigned and a latch cannot be inferred.
        state_next = state;
        case (state)
            RUN: begin
                if (IF_ID_Flush)       state_next = BUBBLE;
                else if (!IF_ID_Write) state_next = HOLD;
            end
            HOLD: begin
                if (IF_ID_Flush)      state_next = BUBBLE;
                else if (IF_ID_Write) state_next = RUN;
            end
            BUBBLE: begin
                if (IF_ID_Flush)       state_next = BUBBLE;
                else if (!IF_ID_Write) state_next = HOLD;
                else                   state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .reset (Reset),
        .inc   (stall_evt),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .reset (Reset),
        .inc   (flush_evt),
        .count (FlushCount)
    );

`ifdef IF_ID_STALL_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

    logic [WDOG_W-1:0] wdog_count;
    logic              wdog_clear;
    logic              hang_q;

    // Run length of HOLD: restarts on any edge that does not land in HOLD.
    assign wdog_clear = Reset || (state_next != HOLD);

    sat_counter #(.W(WDOG_W)) u_wdog_cnt (
        .clk   (Clk),
        .reset (wdog_clear),
        .inc   (1'b1),
        .count (wdog_count)
    );

    // Sticky hang flag, set on the edge that completes WDOG_LIMIT HOLD edges.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hang_q <= 1'b0;
        end else if ((state_next == HOLD) && (wdog_count == WDOG_W'(WDOG_LIMIT - 1))) begin
            hang_q <= 1'b1;
        end
    end

    assign HangDetect = hang_q;
`else
    assign HangDetect = 1'b0;
`endif

endmodule

// File: doc/if_id_pipe_stage.md
Name: if_id_pipe_stage

Overview:
- Consumer end of the hazard-control interface. Owns the PC register and the IF/ID pipeline register, and applies the PCWrite, IF_ID_Write and IF_ID_Flush commands cycle by cycle.
- Inserts NOP bubbles on flush and holds state on stall.
- Tracks a per-entry valid bit and saturating stall/flush event counters for debug.
- Sits between instruction memory / PC-adder logic and the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, encoding injected on flush (sll $0,$0,0).
- CNT_W, 16, width of the stall and flush event counters.
- WDOG_LIMIT, 64, consecutive-stall threshold for the optional watchdog.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous active-high reset
- PCWrite  input  1  1 = PC loads NextPC this cycle
- IF_ID_Write  input  1  1 = IF/ID register loads IF-stage values
- IF_ID_Flush  input  1  1 = IF/ID register loads a bubble
- NextPC  input  32  selected next PC (add/branch/jump mux output)
- Instruction_in  input  32  instruction memory read data at PC
- PCPlus4_in  input  32  PC+4 from the IF adder
- PC  output  32  current fetch address
- IF_ID_Instruction  output  32  instruction presented to ID
- IF_ID_PCPlus4  output  32  PC+4 presented to ID
- IF_ID_Valid  output  1  1 = IF/ID holds a real instruction; 0 = bubble
- StallCount  output  CNT_W  saturating count of stall cycles
- FlushCount  output  CNT_W  saturating count of flush cycles
- HangDetect  output  1  watchdog flag (tied 0 when the feature is disabled)

Behaviour:
- Reset (sync, Reset=1 at a rising edge):
  - PC=RESET_PC, IF_ID_Instruction=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0.
  - StallCount=0, FlushCount=0, HangDetect=0, state=RUN.
  - Reset overrides all other inputs, including mid-stall and mid-flush.
- PC register:
  - On each edge, if PCWrite=1 then PC<=NextPC, else PC holds.
  - PCWrite is independent of the IF/ID register update.
- IF/ID register priority, evaluated at each edge:
  1. IF_ID_Flush=1: Instruction<=NOP_INSTR, PCPlus4<=0, Valid<=0. This applies even when IF_ID_Write=0: flush wins over stall.
  2. Otherwise, IF_ID_Write=1: load Instruction_in and PCPlus4_in, Valid<=1.
  3. Otherwise: hold all three fields.
- Latency: one cycle from instruction-memory output to the IF/ID outputs. All outputs are registered; there is no combinational path from input to output.
- State machine (3 states, next state decided at each edge):
  - RUN: normal operation. Go to HOLD if IF_ID_Write=0 and Flush=0. Go to BUBBLE if Flush=1.
  - HOLD: IF/ID frozen. Stay while Write=0 and Flush=0. Go to BUBBLE on Flush=1. Go to RUN on Write=1.
  - BUBBLE: last edge injected a NOP. Go to BUBBLE if Flush=1 again, which covers back-to-back jump flushes. Go to HOLD if Write=0. Otherwise go to RUN.
- Counters:
  - StallCount increments on every edge with IF_ID_Write=0 and Flush=0.
  - FlushCount increments on every edge with Flush=1.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - PCWrite=0 with Flush=1 is legal: the PC holds and a bubble is inserted.
  - Write=0 with Flush=1 counts as a flush only, not a stall.
- Input X-safety: when Flush=1 or Write=0, Instruction_in is don't-care and is not sampled.

Optional Feature:
- Macro: IF_ID_STALL_WATCHDOG_EN.
- Defined:
  - An internal counter counts consecutive edges spent in HOLD and clears on leaving HOLD.
  - When the counter reaches WDOG_LIMIT, HangDetect is set and stays high (sticky) until Reset.
- Undefined:
  - No counter is built and HangDetect is tied to 0.
  - All other behaviour is identical.

Decomposition:
- Shared package (pipe_pkg) holds:
  - State encoding constants: RUN=2'd0, HOLD=2'd1, BUBBLE=2'd2.
  - NOP_INSTR default and the RESET_PC default.
  - Opcode constants (j=6'b000010, jal=6'b000011, SPECIAL=6'b000000, jr funct=6'b001000), shared with the hazard unit.
- One sub-module: sat_counter (parameterised width, increment enable, sync reset), instantiated twice for StallCount and FlushCount, and a third time for the watchdog when enabled.

Test Plan:
- Reset: hold Reset 2 cycles with PCWrite=1 and NextPC=32'h40 -> PC=0, Valid=0, Instruction=0, counters=0, state=RUN.
- Straight fetch: Write=1, Flush=0, instructions A,B,C on consecutive cycles -> IF/ID shows A,B,C one cycle later with Valid=1; PC follows NextPC; StallCount=0.
- Load-use stall: PCWrite=0 and Write=0 for 1 cycle while IF/ID holds 32'h8C130004 -> the value and PC hold, state=HOLD, StallCount=1, then resume to RUN.
- Flush vs stall: Write=0 and Flush=1 together -> Instruction=NOP, Valid=0, FlushCount=1, StallCount unchanged.
- Triple jump flush: Flush=1 for 3 consecutive cycles -> 3 bubbles, state stays BUBBLE, FlushCount=3, then RUN with the next valid instruction.
- Saturation and watchdog: CNT_W=4, hold Write=0 for 20 cycles -> StallCount=15 and holds. With IF_ID_STALL_WATCHDOG_EN and WDOG_LIMIT=8, HangDetect rises after the 8th stall edge and stays high until Reset.
